// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by the device clock; pin edges acted on 3 clocks late.
// Backpressure: tx_ready only in IDLE; tx_valid elsewhere is ignored. Optional resend: define PS2_TX_RETRY_EN.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES        = 5000,
   parameter int START_TIMEOUT_CYCLES  = 750000,
   parameter int PACKET_TIMEOUT_CYCLES = 100000,
   parameter int MAX_RETRIES           = 2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       kb_clock,
   input  logic       kb_data,
   output logic       kb_clock_oe,
   output logic       kb_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic [1:0] error_code
);

   // One shared cycle counter, wide enough for the largest parameter.
   localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
   localparam int MAX_B   = (MAX_A > PACKET_TIMEOUT_CYCLES) ? MAX_A : PACKET_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_B > MAX_RETRIES) ? MAX_B : MAX_RETRIES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_TO = CW'(START_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] PKT_TO   = CW'(PACKET_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_SAT  = '1;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_START   = 2'b01;
   localparam logic [1:0] ERR_PACKET  = 2'b10;
   localparam logic [1:0] ERR_NACK    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          parity_q, parity_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic [1:0]    err_q, err_d;

   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;
   logic fall;

   logic       pkt_fail;
   logic [1:0] pkt_code;
   logic       retry_ok;
   logic       done_c;
   logic [3:0] bit_nxt;

`ifdef PS2_TX_RETRY_EN
   localparam int RW = $clog2(MAX_RETRIES + 2);
   logic [RW-1:0] retry_q, retry_d;
`endif

   // Pin synchronisers; idle-high reset values so reset release never looks like a fall.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= kb_clock;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= kb_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign fall = clk_prev_q & ~clk_s2_q;

   // State and datapath registers; reset releases both lines without waiting for a clock.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         parity_q  <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         err_q     <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         parity_q  <= parity_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   // Next-state logic: frame sequencing, timeouts and failure handling.
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      parity_d  = parity_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      err_d     = err_q;
      pkt_fail  = 1'b0;
      pkt_code  = ERR_NONE;
      done_c    = 1'b0;
      bit_nxt   = bitcnt_q + 4'd1;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q;
      retry_ok  = (retry_q < RW'(MAX_RETRIES));
`else
      retry_ok  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               shreg_d  = tx_data;
               parity_d = ~^tx_data;
               err_d    = ERR_NONE;
               cnt_d    = '0;
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d  = '0;
`endif
            end
         end
         S_INHIBIT: begin
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            if (cnt_q >= INH_LAST) begin
               // Start bit goes out on the same edge the clock is released.
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               cnt_d     = '0;
               state_d   = S_RTS;
            end
         end
         S_RTS: begin
            if (fall) begin
               bitcnt_d  = '0;
               data_oe_d = ~shreg_q[0];
               cnt_d     = '0;
               state_d   = S_SEND;
            end else if (cnt_q >= START_TO) begin
               // A device that never answers is not worth resending to.
               err_d     = ERR_START;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               state_d   = S_ERROR;
            end
         end
         S_SEND: begin
            if (cnt_q >= PKT_TO) begin
               pkt_fail = 1'b1;
               pkt_code = ERR_PACKET;
            end else if (fall) begin
               bitcnt_d = bit_nxt;
               if (bit_nxt <= 4'd7) begin
                  data_oe_d = ~shreg_q[bit_nxt[2:0]];
               end else if (bit_nxt == 4'd8) begin
                  data_oe_d = ~parity_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (cnt_q >= PKT_TO) begin
               pkt_fail = 1'b1;
               pkt_code = ERR_PACKET;
            end else if (fall) begin
               if (dat_s2_q) begin
                  pkt_fail = 1'b1;
                  pkt_code = ERR_NACK;
               end else begin
                  state_d = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (cnt_q >= PKT_TO) begin
               pkt_fail = 1'b1;
               pkt_code = ERR_PACKET;
            end else if (clk_s2_q && dat_s2_q) begin
               done_c  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERROR: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase

      if (pkt_fail) begin
         if (retry_ok) begin
            // Resend the latched byte from the top, silently.
            cnt_d     = '0;
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_d   = retry_q + RW'(1);
`endif
         end else begin
            err_d     = pkt_code;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_ERROR;
         end
      end
   end

   assign tx_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign tx_done     = done_c;
   assign tx_error    = (state_q == S_ERROR);
   assign error_code  = err_q;
   assign kb_clock_oe = clk_oe_q;
   assign kb_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scaled-down device model on a wired-AND bus.
// Latency: frame timing is paced by the modelled device clock (half period HP system clocks).
// Backpressure: tx_valid is held or pulsed per step to exercise the accept handshake.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int STO = 600;
   localparam int PTO = 500;
   localparam int MR  = 2;
   localparam int HP  = 10;
`ifdef PS2_TX_RETRY_EN
   localparam int FRAMES = 3;
`else
   localparam int FRAMES = 1;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       kb_clock, kb_data;
   logic       kb_clock_oe, kb_data_oe;
   logic       busy, tx_done, tx_error;
   logic [1:0] error_code;

   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [1:0] last_code = 2'b00;
   int cyc = 0;

   logic [9:0] bits, bits2;
   int inh, f1, n, k, d0, e0;

   assign kb_clock = dev_clk & ~kb_clock_oe;
   assign kb_data  = dev_data & ~kb_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT_CYCLES(STO),
      .PACKET_TIMEOUT_CYCLES(PTO),
      .MAX_RETRIES(MR)
   ) dut (
      .clock(clk),
      .resetn(resetn),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .kb_clock(kb_clock),
      .kb_data(kb_data),
      .kb_clock_oe(kb_clock_oe),
      .kb_data_oe(kb_data_oe),
      .busy(busy),
      .tx_done(tx_done),
      .tx_error(tx_error),
      .error_code(error_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters for done/error, sampled away from the active edge.
   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_error === 1'b1) begin
         err_cnt++;
         last_code = error_code;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
      tests++;
      assert (v >= lo && v <= hi) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
      end
   endtask

   // Device side of one frame: waits out the inhibit, then clocks n_falls falling edges.
   task automatic dev_frame(input int n_falls, input logic nack, input logic nxt_vld,
                            input logic [7:0] nxt_dat, output logic [9:0] fb,
                            output int inh_o, output int fall1_o);
      int w;
      int e_start;
      e_start = err_cnt;
      fb = '0;
      inh_o = 0;
      fall1_o = 0;
      w = 0;
      while (kb_clock_oe !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("inhibit_start", {31'd0, kb_clock_oe}, 32'd1);
      while (kb_clock_oe === 1'b1 && inh_o < 4 * INH) begin
         @(negedge clk);
         inh_o++;
      end
      chk("start_bit_low", {31'd0, kb_data}, 32'd0);
      repeat (HP) @(negedge clk);
      for (int i = 1; i <= n_falls; i++) begin
         if (i == 11) dev_data = nack;
         dev_clk = 1'b0;
         if (i == 1) fall1_o = cyc;
         repeat (HP) @(negedge clk);
         if (i <= 10) fb[i-1] = kb_data;
         dev_clk = 1'b1;
         dev_data = 1'b1;
         if (i < 11) repeat (HP) @(negedge clk);
      end
      if (n_falls == 11) begin
         w = 0;
         while (tx_done !== 1'b1 && err_cnt == e_start && kb_clock_oe !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
         end
         tx_valid = nxt_vld;
         tx_data = nxt_dat;
      end
   endtask

   initial begin
      // Reset state
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_clock_oe", {31'd0, kb_clock_oe}, 32'd0);
      chk("rst_data_oe", {31'd0, kb_data_oe}, 32'd0);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
      chk("rst_tx_error", {31'd0, tx_error}, 32'd0);
      chk("rst_error_code", {30'd0, error_code}, 32'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      // 0xED with ACK: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data = 8'hED;
      tx_valid = 1'b1;
      dev_frame(11, 1'b0, 1'b0, 8'h00, bits, inh, f1);
      chk("ed_done_pulse", {31'd0, tx_done}, 32'd1);
      chk("ed_busy_at_done", {31'd0, busy}, 32'd1);
      chk("ed_ready_at_done", {31'd0, tx_ready}, 32'd0);
      @(negedge clk);
      chk("ed_busy_after", {31'd0, busy}, 32'd0);
      chk("ed_ready_after", {31'd0, tx_ready}, 32'd1);
      chk_rng("ed_inhibit_len", inh, INH, INH + 2);
      chk("ed_bits", {22'd0, bits}, 32'h3ED);
      repeat (5) @(negedge clk);
      chk("ed_done_count", done_cnt, d0 + 1);
      chk("ed_err_count", err_cnt, e0);
      chk("ed_idle_again", {31'd0, busy}, 32'd0);

      // 0x01 then 0x00 back-to-back, tx_valid held; tx_data changes mid-frame
      d0 = done_cnt;
      tx_data = 8'h01;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h00;
      dev_frame(11, 1'b0, 1'b1, 8'h00, bits, inh, f1);
      @(negedge clk);
      chk("b2b_done1_count", done_cnt, d0 + 1);
      chk("b2b_ready_between", {31'd0, tx_ready}, 32'd1);
      chk("b2b_bits_01", {22'd0, bits}, 32'h201);
      dev_frame(11, 1'b0, 1'b0, 8'h00, bits2, inh, f1);
      chk("b2b_bits_00", {22'd0, bits2}, 32'h300);
      repeat (5) @(negedge clk);
      chk("b2b_done2_count", done_cnt, d0 + 2);
      chk("b2b_err_count", err_cnt, e0);

      // Device never clocks after request-to-send
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data = 8'hF4;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      k = 0;
      while (kb_clock_oe === 1'b1 && k < 4 * INH) begin
         @(negedge clk);
         k++;
      end
      n = 0;
      while (tx_error !== 1'b1 && n < STO + 100) begin
         @(negedge clk);
         n++;
      end
      chk_rng("start_to_time", n, STO - 1, STO + 3);
      chk("start_to_code", {30'd0, error_code}, 32'd1);
      @(negedge clk);
      chk("start_to_clock_oe", {31'd0, kb_clock_oe}, 32'd0);
      chk("start_to_data_oe", {31'd0, kb_data_oe}, 32'd0);
      chk("start_to_err_single", {31'd0, tx_error}, 32'd0);
      chk("start_to_code_held", {30'd0, error_code}, 32'd1);
      chk("start_to_ready", {31'd0, tx_ready}, 32'd1);

      // 0xFF NACKed on every frame
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int f = 0; f < FRAMES; f++) begin
         dev_frame(11, 1'b1, 1'b0, 8'h00, bits, inh, f1);
         chk("nack_bits", {22'd0, bits}, 32'h3FF);
      end
      repeat (5) @(negedge clk);
      chk("nack_err_count", err_cnt, e0 + 1);
      chk("nack_code_pulse", {30'd0, last_code}, 32'd3);
      chk("nack_code_held", {30'd0, error_code}, 32'd3);
      chk("nack_clock_oe", {31'd0, kb_clock_oe}, 32'd0);
      chk("nack_data_oe", {31'd0, kb_data_oe}, 32'd0);
      chk("nack_no_done", done_cnt, d0);

      // Device stops clocking after fall 5
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      n = 0;
      for (int f = 0; f < FRAMES; f++) begin
         dev_frame(5, 1'b0, 1'b0, 8'h00, bits, inh, f1);
         n = 0;
         while (tx_error !== 1'b1 && kb_clock_oe !== 1'b1 && n < PTO + 100) begin
            @(negedge clk);
            n++;
         end
      end
      chk("pkt_to_seen", {31'd0, tx_error}, 32'd1);
      chk_rng("pkt_to_time", cyc - f1, PTO + 2, PTO + 6);
      chk("pkt_to_code", {30'd0, error_code}, 32'd2);
      @(negedge clk);
      chk("pkt_to_clock_oe", {31'd0, kb_clock_oe}, 32'd0);
      chk("pkt_to_data_oe", {31'd0, kb_data_oe}, 32'd0);
      chk("pkt_to_err_count", err_cnt, e0 + 1);
      chk("pkt_to_no_done", done_cnt, d0);

      // Asynchronous reset while bit 4 of 0x00 is on the wire
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      dev_frame(5, 1'b0, 1'b0, 8'h00, bits, inh, f1);
      chk("arst_pre_data_oe", {31'd0, kb_data_oe}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_clock_oe", {31'd0, kb_clock_oe}, 32'd0);
      chk("arst_data_oe", {31'd0, kb_data_oe}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("arst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      repeat (50) @(negedge clk);
      chk("arst_no_done", done_cnt, d0);
      chk("arst_no_error", err_cnt, e0);
      chk("arst_lines_free", {30'd0, kb_clock_oe, kb_data_oe}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
